// File: rtl/tofed_stream_ctrl_if.sv
// Handshake bundle for tofed_stream_ctrl: parallel frame input and
// stallable serial output. The controller side uses modport master
// (it drives the serial stream and the frame-side ready). The source/sink
// side uses modport slave.
interface tofed_stream_ctrl_if #(
    parameter int FRAME_W = 20
) ();
    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] in_data;
    logic               ser_valid;
    logic               ser_ready;
    logic               ser_bit;
    logic               ser_sof;

    modport master (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_valid, ser_bit, ser_sof
    );

    modport slave (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_valid, ser_bit, ser_sof
    );
endinterface

// File: rtl/tofed_stream_ctrl.sv
// tofed_stream_ctrl: accepts a frame of NUM_FBIBBLES 2-of-5 fbibbles and
// serializes it MSB first onto a stallable one-bit stream. It checks each
// fbibble's ones count and keeps a per-frame error mask plus a saturating
// cumulative error counter.
// Optional feature: define TOFED_STICKY_ERR_EN to build the sticky_err flag.
// Without that macro, sticky_err is tied to 0.
module tofed_stream_ctrl #(
    parameter int FBIBBLE_SIZE   = 5,
    parameter int ONESPERFBIBBLE = 2,
    parameter int NUM_FBIBBLES   = 4,
    parameter int ERRCNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    tofed_stream_ctrl_if.master     bus,
    input  logic                    clr_cnt,
    output logic                    frame_done,
    output logic [NUM_FBIBBLES-1:0] frame_err_mask,
    output logic [ERRCNT_W-1:0]     err_count,
    output logic                    sticky_err
);
    localparam int FRAME_W = FBIBBLE_SIZE * NUM_FBIBBLES;
    localparam int BIT_W   = (FBIBBLE_SIZE > 1) ? $clog2(FBIBBLE_SIZE) : 1;
    localparam int FB_W    = (NUM_FBIBBLES > 1) ? $clog2(NUM_FBIBBLES) : 1;
    localparam int ONES_W  = $clog2(FBIBBLE_SIZE + 1);
    localparam int POP_W   = $clog2(NUM_FBIBBLES + 1);
    localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_reg;
    logic [FRAME_W-1:0]      shift_reg;
    logic [BIT_W-1:0]        bit_idx_reg;
    logic [FB_W-1:0]         fb_idx_reg;
    logic [ONES_W-1:0]       ones_reg;
    logic [NUM_FBIBBLES-1:0] mask_reg;
    logic                    in_ready_reg;
    logic                    ser_valid_reg;
    logic                    ser_sof_reg;
    logic                    frame_done_reg;
    logic [NUM_FBIBBLES-1:0] frame_err_mask_reg;
    logic [ERRCNT_W-1:0]     err_count_reg;

    logic                    xfer;
    logic                    last_bit;
    logic                    last_fb;
    logic                    frame_end;
    logic [ONES_W-1:0]       ones_next;
    logic                    fb_bad;
    logic [NUM_FBIBBLES-1:0] mask_next;
    logic [POP_W-1:0]        pop_cnt;
    logic [ERRCNT_W:0]       err_sum;
    logic [ERRCNT_W-1:0]     err_sat;

    // ser_valid_reg is only high in SHIFT, so it also qualifies the state.
    assign xfer      = ser_valid_reg & bus.ser_ready;
    assign last_bit  = (bit_idx_reg == BIT_W'(FBIBBLE_SIZE - 1));
    assign last_fb   = (fb_idx_reg == FB_W'(NUM_FBIBBLES - 1));
    assign frame_end = xfer & last_bit & last_fb;
    assign ones_next = ones_reg + ONES_W'(shift_reg[FRAME_W-1]);
    assign fb_bad    = (ones_next != ONES_W'(ONESPERFBIBBLE));

    // Mask including the fbibble that is completing on this transfer.
    // It is only consumed when last_bit is set.
    generate
        for (genvar gi = 0; gi < NUM_FBIBBLES; gi++) begin : g_mask
            assign mask_next[gi] = (fb_idx_reg == FB_W'(gi)) ? fb_bad : mask_reg[gi];
        end
    endgenerate

    // Count the bad fbibbles in the completed frame and compute the saturating sum.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_FBIBBLES; i++) begin
            pop_cnt = pop_cnt + POP_W'(mask_next[i]);
        end
        err_sum = {1'b0, err_count_reg} + (ERRCNT_W + 1)'(pop_cnt);
        err_sat = err_sum[ERRCNT_W] ? ERR_MAX : err_sum[ERRCNT_W-1:0];
    end

    // Frame FSM with its shifter, ones counter, and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            shift_reg          <= '0;
            bit_idx_reg        <= '0;
            fb_idx_reg         <= '0;
            ones_reg           <= '0;
            mask_reg           <= '0;
            in_ready_reg       <= 1'b1;
            ser_valid_reg      <= 1'b0;
            ser_sof_reg        <= 1'b0;
            frame_done_reg     <= 1'b0;
            frame_err_mask_reg <= '0;
            err_count_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_reg     <= bus.in_data;
                        bit_idx_reg   <= '0;
                        fb_idx_reg    <= '0;
                        ones_reg      <= '0;
                        mask_reg      <= '0;
                        in_ready_reg  <= 1'b0;
                        ser_valid_reg <= 1'b1;
                        ser_sof_reg   <= 1'b1;
                        state_reg     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        // Shifting in zeros leaves ser_bit at 0 once the frame is drained.
                        shift_reg <= shift_reg << 1;
                        if (last_bit) begin
                            bit_idx_reg <= '0;
                            ones_reg    <= '0;
                            mask_reg    <= mask_next;
                            fb_idx_reg  <= fb_idx_reg + 1'b1;
                            ser_sof_reg <= ~last_fb;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            ones_reg    <= ones_next;
                            ser_sof_reg <= 1'b0;
                        end
                        if (frame_end) begin
                            fb_idx_reg         <= '0;
                            frame_err_mask_reg <= mask_next;
                            err_count_reg      <= err_sat;
                            ser_valid_reg      <= 1'b0;
                            frame_done_reg     <= 1'b1;
                            state_reg          <= DONE;
                        end
                    end
                end
                DONE: begin
                    frame_done_reg <= 1'b0;
                    in_ready_reg   <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            // A clear beats a simultaneous end-of-frame accumulation.
            if (clr_cnt) begin
                err_count_reg <= '0;
            end
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.ser_valid  = ser_valid_reg;
    assign bus.ser_bit    = shift_reg[FRAME_W-1];
    assign bus.ser_sof    = ser_sof_reg;
    assign frame_done     = frame_done_reg;
    assign frame_err_mask = frame_err_mask_reg;
    assign err_count      = err_count_reg;

`ifdef TOFED_STICKY_ERR_EN
    logic sticky_reg;

    // Sticky flag: set by any recorded fbibble error; cleared by clr_cnt, and the clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_reg <= 1'b0;
        end else if (clr_cnt) begin
            sticky_reg <= 1'b0;
        end else if (frame_end && (|mask_next)) begin
            sticky_reg <= 1'b1;
        end
    end

    assign sticky_err = sticky_reg;
`else
    assign sticky_err = 1'b0;
`endif
endmodule

// File: tb/tb_tofed_stream_ctrl.sv
// Self-checking bench for tofed_stream_ctrl. It runs table vectors and
// hand-written corner sequences (saturation, clear, mid-frame reset), then
// randomized frames checked against a frame-level reference model.
module tb_tofed_stream_ctrl;
    localparam int FB    = 5;
    localparam int NFB   = 4;
    localparam int FW    = FB * NFB;
    localparam int ONES  = 2;
    localparam int EMAX  = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic           clr_cnt;
    logic           frame_done;
    logic [NFB-1:0] frame_err_mask;
    logic [7:0]     err_count;
    logic           sticky_err;

    tofed_stream_ctrl_if #(.FRAME_W(FW)) bus ();

    tofed_stream_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .clr_cnt        (clr_cnt),
        .frame_done     (frame_done),
        .frame_err_mask (frame_err_mask),
        .err_count      (err_count),
        .sticky_err     (sticky_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_model    = 0;
    bit sticky_model = 1'b0;

    typedef struct {
        logic [FW-1:0]  frame;
        int             stall_at;
        int             stall_len;
        bit             clr_final;
        logic [NFB-1:0] exp_mask;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference mask: count ones in each 5-bit group and flag any count other than 2.
    function automatic logic [NFB-1:0] model_mask(input logic [FW-1:0] f);
        logic [NFB-1:0] m;
        logic [FB-1:0]  grp;
        m = '0;
        for (int k = 0; k < NFB; k++) begin
            grp  = f[FW-1-k*FB -: FB];
            m[k] = ($countones(grp) != ONES);
        end
        return m;
    endfunction

    function automatic bit exp_sticky();
`ifdef TOFED_STICKY_ERR_EN
        return sticky_model;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready), 1);
        check({tag, "_ser_valid"}, 32'(bus.ser_valid), 0);
        check({tag, "_ser_bit"},   32'(bus.ser_bit), 0);
        check({tag, "_ser_sof"},   32'(bus.ser_sof), 0);
        check({tag, "_done"},      32'(frame_done), 0);
        check({tag, "_mask"},      32'(frame_err_mask), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
        check({tag, "_sticky"},    32'(sticky_err), 0);
    endtask

    // Offer one frame, serialize it with optional stall, final-bit clear, or abort,
    // and check the stream and end-of-frame status. All activity happens at negedges.
    task automatic run_frame(input logic [FW-1:0] frame, input int stall_at, input int stall_len,
                             input bit clr_final, input logic [NFB-1:0] exp_mask, input int abort_at);
        int   w;
        logic eb;
        logic es;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = frame;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom();
        for (int i = 0; i < FW; i++) begin
            eb = frame[FW-1-i];
            es = ((i % FB) == 0);
            if (i == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                err_model    = 0;
                sticky_model = 1'b0;
                check_reset_outputs("abort");
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(frame_done), 0);
                end
                return;
            end
            if (i == stall_at) begin
                bus.ser_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check($sformatf("stall_b%0d", i), {29'd0, bus.ser_valid, bus.ser_bit, bus.ser_sof},
                          {29'd0, 1'b1, eb, es});
                    check("stall_no_done", 32'(frame_done), 0);
                    @(negedge clk);
                end
                bus.ser_ready = 1'b1;
            end
            check($sformatf("bit%0d", i), {29'd0, bus.ser_valid, bus.ser_bit, bus.ser_sof},
                  {29'd0, 1'b1, eb, es});
            clr_cnt = clr_final && (i == FW - 1);
            @(negedge clk);
            clr_cnt = 1'b0;
        end
        if (clr_final) begin
            err_model    = 0;
            sticky_model = 1'b0;
        end else begin
            err_model = err_model + $countones(exp_mask);
            if (err_model > EMAX) err_model = EMAX;
            if (exp_mask != '0) sticky_model = 1'b1;
        end
        check("done_pulse", 32'(frame_done), 1);
        check("done_ser_valid", 32'(bus.ser_valid), 0);
        check("done_in_ready", 32'(bus.in_ready), 0);
        check("frame_err_mask", 32'(frame_err_mask), 32'(exp_mask));
        check("err_count", 32'(err_count), 32'(err_model));
        check("sticky_err", 32'(sticky_err), 32'(exp_sticky()));
        @(negedge clk);
        check("idle_done_low", 32'(frame_done), 0);
        check("idle_in_ready", 32'(bus.in_ready), 1);
        check("mask_hold", 32'(frame_err_mask), 32'(exp_mask));
    endtask

    initial begin
        logic [FW-1:0] f;
        logic [FB-1:0] g;
        int p0, p1;

        vecs[0] = '{20'h19531, -1, 0, 1'b0, 4'b0000};
        vecs[1] = '{20'h00000, -1, 0, 1'b0, 4'b1111};
        vecs[2] = '{20'hE1531, -1, 0, 1'b0, 4'b0001};
        vecs[3] = '{20'h19531,  7, 3, 1'b0, 4'b0000};
        vecs[4] = '{20'hFFFFF,  0, 2, 1'b0, 4'b1111};
        vecs[5] = '{20'h00000, -1, 0, 1'b1, 4'b1111};

        reset         = 1'b1;
        clr_cnt       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.ser_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset");

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].frame, vecs[v].stall_at, vecs[v].stall_len,
                      vecs[v].clr_final, vecs[v].exp_mask, -1);
        end

        // Saturation: 64 all-zero frames reach 255, and the 65th frame holds there.
        for (int n = 0; n < 65; n++) begin
            run_frame(20'h00000, -1, 0, 1'b0, 4'b1111, -1);
            if (n == 63) check("sat_64", 32'(err_count), EMAX);
        end
        check("sat_65", 32'(err_count), EMAX);

        // A clear while idle.
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        err_model    = 0;
        sticky_model = 1'b0;
        check("idle_clr_count", 32'(err_count), 0);
        check("idle_clr_sticky", 32'(sticky_err), 0);

        // Clear on the final-bit edge after accumulating some errors.
        run_frame(20'hE1531, -1, 0, 1'b0, 4'b0001, -1);
        run_frame(20'h00000, -1, 0, 1'b1, 4'b1111, -1);

        // Reset at bit 10, then a normal frame.
        run_frame(20'h00000, -1, 0, 1'b0, 4'b1111, 10);
        run_frame(20'hE1531, -1, 0, 1'b0, 4'b0001, -1);

        // Randomized frames: fbibbles are either valid 2-of-5 codes or random bits.
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < NFB; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    p0 = $urandom_range(0, FB - 1);
                    p1 = (p0 + $urandom_range(1, FB - 1)) % FB;
                    g  = '0;
                    g[p0] = 1'b1;
                    g[p1] = 1'b1;
                end else begin
                    g = FB'($urandom());
                end
                f[FW-1-k*FB -: FB] = g;
            end
            run_frame(f, $urandom_range(0, FW - 1), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0), model_mask(f), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
